// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// the processor ID constant and the number of hardware interrupt lines.
package cp0_pkg;

  localparam logic [3:0] REG_SR    = 4'd12;
  localparam logic [3:0] REG_CAUSE = 4'd13;
  localparam logic [3:0] REG_EPC   = 4'd14;
  localparam logic [3:0] REG_PRID  = 4'd15;

  localparam int N_INT   = 6;
  localparam int IM_LSB  = 10;
  localparam int IM_MSB  = IM_LSB + N_INT - 1;
  localparam int IP_LSB  = 10;
  localparam int IP_MSB  = IP_LSB + N_INT - 1;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  localparam logic [31:0] PRID_VAL = 32'h4A55_0001;

  function automatic logic [31:0] pack_sr(input logic [N_INT-1:0] im,
                                          input logic exl,
                                          input logic ie);
    logic [31:0] r;
    r = 32'h0;
    r[IM_MSB:IM_LSB] = im;
    r[EXL_BIT]       = exl;
    r[IE_BIT]        = ie;
    return r;
  endfunction

  function automatic logic [31:0] pack_cause(input logic [N_INT-1:0] ip);
    logic [31:0] r;
    r = 32'h0;
    r[IP_MSB:IP_LSB] = ip;
    return r;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// CP0 access bundle: mfc0/mtc0 register port, exception controls from the
// controller FSM, and the interrupt/EPC outputs back to the core.
interface cp0_if;
  import cp0_pkg::*;

  logic [3:0]       sel;
  logic             wen;
  logic [31:0]      din;
  logic [31:0]      dout;
  logic [31:0]      pc_in;
  logic [N_INT-1:0] hwint;
  logic             exlset;
  logic             exlclr;
  logic             epcwr;
  logic             int_req;
  logic [31:0]      epc_out;

  modport master (
    output sel, wen, din, pc_in, hwint, exlset, exlclr, epcwr,
    input  dout, int_req, epc_out
  );

  modport slave (
    input  sel, wen, din, pc_in, hwint, exlset, exlclr, epcwr,
    output dout, int_req, epc_out
  );

endinterface

// File: rtl/cp0_sync.sv
// Two-flop synchronizer with asynchronous active-high reset; q is the
// second stage.
module cp0_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PrID registers, synchronized interrupt
// pending bits and a registered-source interrupt request.
module cp0
  import cp0_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  cp0_if.slave  bus
);

  logic [N_INT-1:0] im_d, im_q;
  logic             exl_d, exl_q;
  logic             ie_d, ie_q;
  logic [29:0]      epc_d, epc_q;
  logic [N_INT-1:0] ip;
  logic [31:0]      epc_full;
  logic [31:0]      dout_c;

  cp0_sync #(.WIDTH(N_INT)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.hwint),
    .q   (ip)
  );

  // Later assignments take priority: exlset over exlclr over the mtc0 EXL bit,
  // and epcwr over the mtc0 EPC write.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    epc_d = epc_q;
    if (bus.wen && bus.sel == REG_SR) begin
      im_d  = bus.din[IM_MSB:IM_LSB];
      exl_d = bus.din[EXL_BIT];
      ie_d  = bus.din[IE_BIT];
    end
    if (bus.exlclr) exl_d = 1'b0;
    if (bus.exlset) exl_d = 1'b1;
    if (bus.wen && bus.sel == REG_EPC) epc_d = bus.din[31:2];
    if (bus.epcwr) epc_d = bus.pc_in[31:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      epc_q <= epc_d;
    end
  end

  assign epc_full = {epc_q, 2'b00};

  always_comb begin
    dout_c = 32'h0;
    case (bus.sel)
      REG_SR:    dout_c = pack_sr(im_q, exl_q, ie_q);
      REG_CAUSE: dout_c = pack_cause(ip);
      REG_EPC:   dout_c = epc_full;
      REG_PRID:  dout_c = PRID_VAL;
      default:   dout_c = 32'h0;
    endcase
  end

  // Only flop outputs feed int_req, so async reset drops it with no clock.
  assign bus.int_req = (|(ip & im_q)) & ie_q & ~exl_q;
  assign bus.dout    = dout_c;
  assign bus.epc_out = epc_full;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: register access, interrupt latency,
// exception entry/return priorities and asynchronous reset.
module tb_cp0;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  cp0_if bus ();

  cp0 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] s, input logic [31:0] exp);
    bus.sel = s;
    #1;
    chk(tag, bus.dout, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst        = 1'b1;
    bus.sel    = 4'd0;
    bus.wen    = 1'b0;
    bus.din    = 32'h0;
    bus.pc_in  = 32'h0;
    bus.hwint  = 6'b0;
    bus.exlset = 1'b0;
    bus.exlclr = 1'b0;
    bus.epcwr  = 1'b0;

    // Reset state
    #3;
    chk("rst_int_req", {31'h0, bus.int_req}, 32'h0);
    chk("rst_epc_out", bus.epc_out, 32'h0);
    rd("rst_sr", 4'd12, 32'h0);
    rd("rst_cause", 4'd13, 32'h0);
    rd("rst_epc", 4'd14, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Enable IM[0] + IE, then raise hwint[0]: int_req two edges later
    bus.sel = 4'd12; bus.wen = 1'b1; bus.din = 32'h0000_0401;
    #1;
    chk("no_write_through", bus.dout, 32'h0);
    tick();
    bus.wen = 1'b0;
    rd("sr_after_write", 4'd12, 32'h0000_0401);
    bus.hwint = 6'b000001;
    tick();
    chk("int_req_1edge", {31'h0, bus.int_req}, 32'h0);
    tick();
    chk("int_req_2edge", {31'h0, bus.int_req}, 32'h1);
    rd("cause_ip", 4'd13, 32'h0000_0400);

    // Interrupt entry
    bus.pc_in = 32'h0000_3008; bus.exlset = 1'b1; bus.epcwr = 1'b1;
    tick();
    bus.exlset = 1'b0; bus.epcwr = 1'b0;
    chk("entry_epc_out", bus.epc_out, 32'h0000_3008);
    rd("entry_sr", 4'd12, 32'h0000_0403);
    chk("entry_int_req", {31'h0, bus.int_req}, 32'h0);

    // eret with line still high, then drop line
    bus.exlclr = 1'b1;
    tick();
    bus.exlclr = 1'b0;
    chk("eret_int_req", {31'h0, bus.int_req}, 32'h1);
    bus.hwint = 6'b0;
    tick();
    chk("drop_1edge", {31'h0, bus.int_req}, 32'h1);
    tick();
    chk("drop_2edge", {31'h0, bus.int_req}, 32'h0);

    // exlset beats exlclr
    bus.exlset = 1'b1; bus.exlclr = 1'b1;
    tick();
    bus.exlset = 1'b0; bus.exlclr = 1'b0;
    rd("exl_prio", 4'd12, 32'h0000_0403);

    // mtc0 SR with exlclr: EXL cleared, IM/IE from din
    bus.sel = 4'd12; bus.wen = 1'b1; bus.din = 32'h0000_0803; bus.exlclr = 1'b1;
    tick();
    bus.wen = 1'b0; bus.exlclr = 1'b0;
    rd("sr_wen_exlclr", 4'd12, 32'h0000_0801);

    // mtc0 SR with exlset: EXL set, IM/IE from din
    bus.sel = 4'd12; bus.wen = 1'b1; bus.din = 32'h0000_FC00; bus.exlset = 1'b1;
    tick();
    bus.wen = 1'b0; bus.exlset = 1'b0;
    rd("sr_wen_exlset", 4'd12, 32'h0000_FC02);

    // Cause is not writable
    bus.sel = 4'd13; bus.wen = 1'b1; bus.din = 32'hFFFF_FFFF;
    tick();
    bus.wen = 1'b0;
    rd("cause_ro", 4'd13, 32'h0);

    // epcwr beats mtc0 EPC
    bus.pc_in = 32'h0000_1003; bus.epcwr = 1'b1;
    bus.sel = 4'd14; bus.wen = 1'b1; bus.din = 32'h1234_5677;
    tick();
    bus.wen = 1'b0; bus.epcwr = 1'b0;
    chk("epc_prio", bus.epc_out, 32'h0000_1000);

    // mtc0 EPC alignment, PrID, unmapped register, all-ones SR
    bus.sel = 4'd14; bus.wen = 1'b1; bus.din = 32'hFFFF_FFFF;
    tick();
    bus.wen = 1'b0;
    chk("epc_align", bus.epc_out, 32'hFFFF_FFFC);
    bus.sel = 4'd3;
    #1;
    chk("epc_out_any_sel", bus.epc_out, 32'hFFFF_FFFC);
    rd("prid", 4'd15, 32'h4A55_0001);
    rd("unmapped", 4'd3, 32'h0);
    bus.sel = 4'd12; bus.wen = 1'b1; bus.din = 32'hFFFF_FFFF;
    tick();
    bus.wen = 1'b0;
    rd("sr_mask", 4'd12, 32'h0000_FC03);

    // Async reset while int_req is high
    bus.sel = 4'd12; bus.wen = 1'b1; bus.din = 32'h0000_0401;
    bus.hwint = 6'b000001;
    tick();
    bus.wen = 1'b0;
    tick();
    chk("pre_rst_int_req", {31'h0, bus.int_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_int_req", {31'h0, bus.int_req}, 32'h0);
    rd("async_rst_sr", 4'd12, 32'h0);
    rd("async_rst_epc", 4'd14, 32'h0);
    chk("async_rst_epc_out", bus.epc_out, 32'h0);
    rd("async_rst_cause", 4'd13, 32'h0);

    // Line already high at reset release: IP after 2 edges
    tick();
    rst = 1'b0;
    bus.sel = 4'd13;
    tick();
    chk("post_rst_ip_1edge", bus.dout, 32'h0);
    tick();
    chk("post_rst_ip_2edge", bus.dout, 32'h0000_0400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port sel  input  4  register number for read/write: 12=SR, 13=Cause, 14=EPC, 15=PrID.
REQ-004 SHALL have port wen  input  1  software write strobe (mtc0) into the register chosen by sel.
REQ-005 SHALL have port din  input  32  write data from the GPR rt.
REQ-006 SHALL have port dout  output  32  read data for the register chosen by sel (mfc0).
REQ-007 SHALL have port pc_in  input  32  current PC register value, the address of the next instruction.
REQ-008 SHALL have port hwint  input  6  asynchronous level-sensitive device interrupt lines.
REQ-009 SHALL have port exlset  input  1  interrupt entry: set EXL.
REQ-010 SHALL have port exlclr  input  1  eret: clear EXL.
REQ-011 SHALL have port epcwr  input  1  interrupt entry: capture pc_in into EPC.
REQ-012 SHALL have port int_req  output  1  interrupt request to the controller FSM.
REQ-013 SHALL have port epc_out  output  32  EPC value, always visible to the nPC mux for eret.

Function
REQ-014 SR SHALL hold IM in [15:10], EXL in [1] and IE in [0]; all other bits SHALL read 0.
REQ-015 Cause SHALL expose IP in [15:10], all other bits 0; software writes to Cause SHALL be ignored.
REQ-016 EPC SHALL be 32 bits with [1:0] always 0.
REQ-017 PrID SHALL be the read-only constant 32'h4A55_0001.
REQ-018 dout SHALL be combinational from sel and the registers; sel outside 12..15 SHALL return 32'h0.
REQ-019 Each hwint bit SHALL pass through a 2-flop synchronizer; the second stage SHALL be IP.
REQ-020 An hwint bit asserted before edge N SHALL appear in IP after edge N+1, a latency of 2 edges.
REQ-021 IP SHALL track the line level, so the device holds the line until it is serviced.
REQ-022 int_req SHALL equal OR(IP & IM) AND IE AND NOT EXL, driven only from registers with no combinational path from any input.
REQ-023 wen with sel=12 SHALL load IM, EXL and IE from din at the edge; wen with sel=14 SHALL load EPC with {din[31:2],2'b00}.
REQ-024 epcwr SHALL load EPC with {pc_in[31:2],2'b00} at the edge.
REQ-025 If epcwr and wen(sel=14) are asserted in the same cycle, epcwr SHALL win.
REQ-026 exlset SHALL set EXL at the edge, and int_req SHALL be 0 from the following cycle.
REQ-027 exlclr SHALL clear EXL at the edge.
REQ-028 If exlset and exlclr are asserted in the same cycle, exlset SHALL win.
REQ-029 If wen(sel=12) and exlset are asserted in the same cycle, EXL SHALL become 1 and IM/IE SHALL load from din.
REQ-030 If wen(sel=12) and exlclr are asserted in the same cycle, EXL SHALL become 0 and IM/IE SHALL load from din.
REQ-031 A write SHALL be visible on dout and int_req in the cycle after the edge; there is no write-through.
REQ-032 epc_out SHALL always equal EPC, independent of sel.

Reset
REQ-033 rst SHALL asynchronously clear IM, EXL, IE, EPC and both synchronizer stages.
REQ-034 int_req and epc_out SHALL be 0 during reset; dout SHALL read 0 for sel=12, 13 and 14.
REQ-035 After rst deasserts, an hwint already high SHALL reach IP after 2 edges.
REQ-036 Reset asserted mid-operation SHALL drop int_req immediately, without waiting for a clock edge.

Structure
REQ-037 A shared package cp0_pkg SHALL hold: register numbers 12..15, the SR/Cause bit-field positions, the PrID constant, and the interrupt line count 6.
REQ-038 The synchronizer SHALL be a sub-module cp0_sync, parameterised by width and with async reset; cp0 SHALL instantiate it once with width 6.

Verification
REQ-039 Scenario: reset; wen, sel=12, din=32'h0000_0401 (IM[0]=1, IE=1); hwint=6'b000001 -> int_req=1 exactly 2 edges after hwint; reading sel=13 returns 32'h0000_0400.
REQ-040 Scenario: with int_req=1, pulse exlset+epcwr with pc_in=32'h0000_3008 -> EPC=32'h0000_3008, SR reads 32'h0000_0403, int_req=0 the next cycle.
REQ-041 Scenario: pulse exlclr with hwint still high -> int_req=1 the next cycle; then drop hwint -> int_req=0 two edges later.
REQ-042 Scenario: exlset and exlclr together -> EXL=1; epcwr and wen(sel=14, din=32'h1234_5677) together -> EPC=pc_in, not 32'h1234_5674.
REQ-043 Scenario: wen sel=14 din=32'hFFFF_FFFF -> epc_out=32'hFFFF_FFFC; sel=15 reads 32'h4A55_0001; sel=3 reads 32'h0.
REQ-044 Scenario: assert rst mid-cycle while int_req=1 -> int_req=0 immediately, and SR and EPC read 0.
